// File: rtl/fifo_drain_serializer_if.sv
// rtl/fifo_drain_serializer_if.sv - dequeue-side and beat-enqueue method interfaces
// master calls the method (drives ENA); slave provides it (drives RDY and data).
interface fifo_deq_if #(
    parameter int width = 32
);
    logic [width-1:0] first;
    logic             first__RDY;
    logic             deq__RDY;
    logic             deq__ENA;

    modport master (input first, first__RDY, deq__RDY, output deq__ENA);
    modport slave  (output first, first__RDY, deq__RDY, input deq__ENA);
endinterface

interface beat_enq_if #(
    parameter int beat = 8
);
    logic            enq__RDY;
    logic            enq__ENA;
    logic [beat-1:0] enq_v;
    logic            enq_last;

    modport master (input enq__RDY, output enq__ENA, enq_v, enq_last);
    modport slave  (output enq__RDY, input enq__ENA, enq_v, enq_last);
endinterface

// File: rtl/fifo_drain_serializer.sv
// rtl/fifo_drain_serializer.sv - pops wide FIFO words and emits them as LSB-first beats
// A new word is captured on the final beat of the previous one, so words stream with no bubble.
module fifo_drain_serializer #(
    parameter int width = 32,
    parameter int beat  = 8,
    parameter int cntw  = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    fifo_deq_if.master      src,
    beat_enq_if.master      dst,
    output logic [cntw-1:0] words_done,
    output logic            busy
);

    localparam int N    = width / beat;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    if (width % beat != 0) begin : g_bad_ratio
        $error("fifo_drain_serializer: width must be an integer multiple of beat");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [width-1:0]  sr_q, sr_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [cntw-1:0]   words_q, words_d;

    logic sending;
    logic is_last;
    logic enq_ena;
    logic load;

    // Gating with nRST keeps every handshake output quiet while reset is held.
    assign sending = nRST && (state_q == SEND);
    assign is_last = sending && (idx_q == LAST_IDX);
    assign enq_ena = sending && dst.enq__RDY;
    assign load    = nRST && src.deq__RDY && src.first__RDY
                     && ((state_q == IDLE) || (enq_ena && is_last));

    assign src.deq__ENA = load;
    assign dst.enq__ENA = enq_ena;
    assign dst.enq_v    = sr_q[beat-1:0];
    assign dst.enq_last = is_last;
    assign busy         = sending;
    assign words_done   = words_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        words_d = words_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    sr_d    = src.first;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (enq_ena) begin
                    if (!is_last) begin
                        sr_d  = sr_q >> beat;
                        idx_d = idx_q + IDXW'(1);
                    end else begin
                        words_d = words_q + cntw'(1);
                        if (load) begin
                            sr_d  = src.first;
                            idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// tb/tb_fifo_drain_serializer.sv - directed vector bench for fifo_drain_serializer
// DUT a: 32/8 with a 16-bit counter; DUT b: 8/8 with a 4-bit counter for wrap and N==1.
module tb_fifo_drain_serializer;

    logic       CLK = 1'b0;
    logic       nrst_a = 1'b0;
    logic       nrst_b = 1'b0;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;
    logic [15:0] words_a;
    logic [3:0]  words_b;
    logic        busy_a, busy_b;

    fifo_deq_if #(.width(32)) src_a ();
    beat_enq_if #(.beat(8))   dst_a ();
    fifo_deq_if #(.width(8))  src_b ();
    beat_enq_if #(.beat(8))   dst_b ();

    fifo_drain_serializer #(.width(32), .beat(8), .cntw(16)) dut_a (
        .CLK(CLK), .nRST(nrst_a), .src(src_a), .dst(dst_a), .words_done(words_a), .busy(busy_a)
    );
    fifo_drain_serializer #(.width(8), .beat(8), .cntw(4)) dut_b (
        .CLK(CLK), .nRST(nrst_b), .src(src_b), .dst(dst_b), .words_done(words_b), .busy(busy_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        nrst, rdy, en, push;
        logic [31:0] data;
        logic        deq, enq;
        logic [7:0]  v;
        logic        chk_v, last, busy;
        logic [15:0] words;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] qa[$];
    logic [7:0]  qb[$];
    int          checks = 0;
    int          errors = 0;

    logic        s_deq_a, s_enq_a, s_last_a, s_busy_a;
    logic [7:0]  s_v_a;
    logic [15:0] s_w_a;
    logic        s_deq_b, s_enq_b, s_last_b, s_busy_b;
    logic [7:0]  s_v_b;
    logic [3:0]  s_w_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        src_a.first      = (qa.size() > 0) ? qa[0] : 32'h0;
        src_a.first__RDY = en_a && (qa.size() > 0);
        src_a.deq__RDY   = en_a && (qa.size() > 0);
        src_b.first      = (qb.size() > 0) ? qb[0] : 8'h0;
        src_b.first__RDY = en_b && (qb.size() > 0);
        src_b.deq__RDY   = en_b && (qb.size() > 0);
    endtask

    // Pops follow the ENA sampled on the previous negedge; inputs change 1 ns after posedge.
    task automatic cycle(input logic na, input logic ra, input logic ea,
                         input logic nb, input logic eb);
        @(posedge CLK);
        if (s_deq_a === 1'b1 && qa.size() > 0) qa.delete(0);
        if (s_deq_b === 1'b1 && qb.size() > 0) qb.delete(0);
        #1;
        nrst_a = na; dst_a.enq__RDY = ra; en_a = ea;
        nrst_b = nb; dst_b.enq__RDY = 1'b1; en_b = eb;
        drive_src();
        @(negedge CLK);
        s_deq_a = src_a.deq__ENA; s_enq_a = dst_a.enq__ENA; s_v_a = dst_a.enq_v;
        s_last_a = dst_a.enq_last; s_busy_a = busy_a; s_w_a = words_a;
        s_deq_b = src_b.deq__ENA; s_enq_b = dst_b.enq__ENA; s_v_b = dst_b.enq_v;
        s_last_b = dst_b.enq_last; s_busy_b = busy_b; s_w_b = words_b;
    endtask

    task automatic expect_a(input string tag, input logic deq, input logic enq, input logic [7:0] v,
                            input logic chk_v, input logic last, input logic busy, input logic [15:0] w);
        chk({tag, " deq_ena"}, 32'(s_deq_a), 32'(deq));
        chk({tag, " enq_ena"}, 32'(s_enq_a), 32'(enq));
        chk({tag, " last"},    32'(s_last_a), 32'(last));
        chk({tag, " busy"},    32'(s_busy_a), 32'(busy));
        chk({tag, " words"},   32'(s_w_a), 32'(w));
        if (chk_v) chk({tag, " beat"}, 32'(s_v_a), 32'(v));
    endtask

    task automatic expect_b(input string tag, input logic deq, input logic enq, input logic [7:0] v,
                            input logic last, input logic busy, input logic [3:0] w);
        chk({tag, " deq_ena"}, 32'(s_deq_b), 32'(deq));
        chk({tag, " enq_ena"}, 32'(s_enq_b), 32'(enq));
        chk({tag, " last"},    32'(s_last_b), 32'(last));
        chk({tag, " busy"},    32'(s_busy_b), 32'(busy));
        chk({tag, " words"},   32'(s_w_b), 32'(w));
        if (enq) chk({tag, " beat"}, 32'(s_v_b), 32'(v));
    endtask

    function automatic vec_t mk(logic nrst, logic rdy, logic en, logic push, logic [31:0] data,
                                logic deq, logic enq, logic [7:0] v, logic chk_v,
                                logic last, logic busy, logic [15:0] words);
        vec_t r;
        r.nrst = nrst; r.rdy = rdy; r.en = en; r.push = push; r.data = data;
        r.deq = deq; r.enq = enq; r.v = v; r.chk_v = chk_v;
        r.last = last; r.busy = busy; r.words = words;
        return r;
    endfunction

    initial begin
        //               nrst rdy en push data          deq enq v      chkv last busy words
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 0, 8'h00, 0, 0, 0, 16'd0));
        tbl.push_back(mk(1, 1, 1, 1, 32'hA1B2C3D4,   1, 0, 8'h00, 0, 0, 0, 16'd0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'hD4, 1, 0, 1, 16'd0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'hC3, 1, 0, 1, 16'd0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'hB2, 1, 0, 1, 16'd0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'hA1, 1, 1, 1, 16'd0));
        tbl.push_back(mk(1, 1, 0, 1, 32'h11223344,   0, 0, 8'h00, 0, 0, 0, 16'd1));
        tbl.push_back(mk(1, 1, 1, 1, 32'h55667788,   1, 0, 8'h00, 0, 0, 0, 16'd1));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'h44, 1, 0, 1, 16'd1));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'h33, 1, 0, 1, 16'd1));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'h22, 1, 0, 1, 16'd1));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          1, 1, 8'h11, 1, 1, 1, 16'd1));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'h88, 1, 0, 1, 16'd2));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'h77, 1, 0, 1, 16'd2));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'h66, 1, 0, 1, 16'd2));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'h55, 1, 1, 1, 16'd2));
        tbl.push_back(mk(1, 1, 1, 1, 32'hDEADBEEF,   1, 0, 8'h00, 0, 0, 0, 16'd3));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'hEF, 1, 0, 1, 16'd3));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,          0, 0, 8'hBE, 1, 0, 1, 16'd3));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,          0, 0, 8'hBE, 1, 0, 1, 16'd3));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,          0, 0, 8'hBE, 1, 0, 1, 16'd3));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'hBE, 1, 0, 1, 16'd3));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'hAD, 1, 0, 1, 16'd3));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 1, 8'hDE, 1, 1, 1, 16'd3));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,          0, 0, 8'h00, 0, 0, 0, 16'd4));

        dst_a.enq__RDY = 1'b1;
        dst_b.enq__RDY = 1'b1;
        drive_src();
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].push) qa.push_back(tbl[i].data);
            cycle(tbl[i].nrst, tbl[i].rdy, tbl[i].en, 0, 0);
            expect_a($sformatf("vec%0d", i), tbl[i].deq, tbl[i].enq, tbl[i].v, tbl[i].chk_v,
                     tbl[i].last, tbl[i].busy, tbl[i].words);
        end

        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, 1, 0, 0);
            expect_a($sformatf("empty%0d", i), 0, 0, 8'h00, 0, 0, 0, 16'd4);
        end

        qa.push_back(32'hCAFEF00D);
        cycle(1, 1, 1, 0, 0); expect_a("rst_pop",  1, 0, 8'h00, 0, 0, 0, 16'd4);
        cycle(1, 1, 1, 0, 0); expect_a("rst_b0",   0, 1, 8'h0D, 1, 0, 1, 16'd4);
        cycle(1, 1, 1, 0, 0); expect_a("rst_b1",   0, 1, 8'hF0, 1, 0, 1, 16'd4);
        cycle(0, 1, 1, 0, 0); expect_a("rst_hold", 0, 0, 8'h00, 0, 0, 0, 16'd4);
        cycle(1, 1, 0, 0, 0); expect_a("rst_idle", 0, 0, 8'h00, 0, 0, 0, 16'd0);
        cycle(1, 1, 0, 0, 0); expect_a("rst_quiet", 0, 0, 8'h00, 0, 0, 0, 16'd0);
        qa.push_back(32'h01020304);
        cycle(1, 1, 1, 0, 0); expect_a("new_pop",  1, 0, 8'h00, 0, 0, 0, 16'd0);
        cycle(1, 1, 1, 0, 0); expect_a("new_b0",   0, 1, 8'h04, 1, 0, 1, 16'd0);
        cycle(1, 1, 1, 0, 0); expect_a("new_b1",   0, 1, 8'h03, 1, 0, 1, 16'd0);
        cycle(1, 1, 1, 0, 0); expect_a("new_b2",   0, 1, 8'h02, 1, 0, 1, 16'd0);
        cycle(1, 1, 1, 0, 0); expect_a("new_b3",   0, 1, 8'h01, 1, 1, 1, 16'd0);
        cycle(1, 1, 1, 0, 0); expect_a("new_done", 0, 0, 8'h00, 0, 0, 0, 16'd1);

        for (int k = 1; k <= 17; k++) qb.push_back(8'(k));
        cycle(1, 1, 0, 1, 1);
        expect_b("wrap_pop", 1, 0, 8'h00, 0, 0, 4'd0);
        for (int k = 1; k <= 17; k++) begin
            cycle(1, 1, 0, 1, 1);
            expect_b($sformatf("wrap%0d", k), (k < 17), 1, 8'(k), 1, 1, 4'((k - 1) % 16));
        end
        cycle(1, 1, 0, 1, 1);
        expect_b("wrap_end", 0, 0, 8'h00, 0, 0, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
